// File: rtl/c2h_qdma_adapter_pkg.sv
// Shared types and helpers for the C2H-to-QDMA adapter: FSM encoding,
// completion entry layout and per-packet length arithmetic.
package c2h_qdma_adapter_pkg;

  localparam int DATA_BYTES = 64;
  localparam int QID_W = 11;
  localparam logic [1:0] CPL_SIZE_8B = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]      seq;
    logic [4:0]       rsvd;
    logic [QID_W-1:0] qid;
    logic [15:0]      len;
  } cpl_entry_t;

  // Empty bytes in the final beat; a multiple of 64 leaves none.
  function automatic logic [5:0] mty_of(input logic [15:0] size);
    return 6'd0 - size[5:0];
  endfunction

  function automatic logic [10:0] beats_of(input logic [15:0] size);
    logic [16:0] w_sum;
    w_sum = {1'b0, size} + 17'(DATA_BYTES - 1);
    return w_sum[16:6];
  endfunction

endpackage

// File: rtl/c2h_cpl_fifo.sv
// Pending-completion FIFO with first-word-fall-through head output.
module c2h_cpl_fifo
  import c2h_qdma_adapter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  cpl_entry_t i_data,
  input  logic       i_pop,
  output cpl_entry_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  cpl_entry_t  r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/c2h_qdma_adapter.sv
// Re-forms the steered C2H packet stream into the QDMA C2H data interface
// and issues one 8-byte completion per forwarded packet.
module c2h_qdma_adapter
  import c2h_qdma_adapter_pkg::state_e, c2h_qdma_adapter_pkg::ST_IDLE,
         c2h_qdma_adapter_pkg::ST_PASS, c2h_qdma_adapter_pkg::ST_DROP,
         c2h_qdma_adapter_pkg::cpl_entry_t, c2h_qdma_adapter_pkg::mty_of,
         c2h_qdma_adapter_pkg::beats_of, c2h_qdma_adapter_pkg::CPL_SIZE_8B;
#(
  parameter int DATA_W         = 512,
  parameter int QID_W          = 11,
  parameter int CPL_FIFO_DEPTH = 8
) (
  input  logic              axis_aclk,
  input  logic              axil_aresetn,
  input  logic              s_axis_c2h_tvalid,
  input  logic [DATA_W-1:0] s_axis_c2h_tdata,
  input  logic              s_axis_c2h_tlast,
  input  logic [15:0]       s_axis_c2h_tuser_size,
  input  logic [QID_W-1:0]  s_axis_c2h_tuser_qid,
  output logic              s_axis_c2h_tready,
  output logic              m_axis_qdma_c2h_tvalid,
  output logic [DATA_W-1:0] m_axis_qdma_c2h_tdata,
  output logic              m_axis_qdma_c2h_tlast,
  output logic [15:0]       m_axis_qdma_c2h_ctrl_len,
  output logic [QID_W-1:0]  m_axis_qdma_c2h_ctrl_qid,
  output logic              m_axis_qdma_c2h_ctrl_has_cmpt,
  output logic [5:0]        m_axis_qdma_c2h_mty,
  input  logic              m_axis_qdma_c2h_tready,
  output logic              m_axis_qdma_cpl_tvalid,
  output logic [DATA_W-1:0] m_axis_qdma_cpl_tdata,
  output logic [1:0]        m_axis_qdma_cpl_size,
  output logic [QID_W-1:0]  m_axis_qdma_cpl_ctrl_qid,
  input  logic              m_axis_qdma_cpl_tready,
  output logic [31:0]       stat_pkt_cnt,
  output logic [31:0]       stat_drop_cnt,
  output logic [31:0]       stat_len_err_cnt,
  output logic [1:0]        o_dbg_state
);

  // Every stream follows AXI-S rules: a beat transfers on a clock edge where
  // valid and ready are both high; valid and payload hold until then.
  localparam int CNT_W    = $clog2(CPL_FIFO_DEPTH) + 1;
  localparam int QID_LSB  = 6;
  localparam int LEN_LSB  = QID_LSB + QID_W;
  localparam int LAST_BIT = LEN_LSB + 16;
  localparam int BW       = LAST_BIT + 1 + DATA_W;

  state_e           r_state, w_next;
  logic             r_rdy_en;
  logic [15:0]      r_len;
  logic [QID_W-1:0] r_qid;
  logic [10:0]      r_exp_beats;
  logic [15:0]      r_beat_cnt;
  logic [CNT_W-1:0] r_pend;
  logic [31:0]      r_seq;
  logic             r_out_valid, r_skid_valid;
  logic [BW-1:0]    r_out, r_skid;
  logic             w_s_tready, w_in_hs, w_start, w_fwd, w_can_start, w_size_zero;
  logic [15:0]      w_len, w_beats_now;
  logic [QID_W-1:0] w_qid;
  logic [10:0]      w_exp;
  logic [5:0]       w_mty;
  logic [BW-1:0]    w_beat;
  logic             w_out_free, w_push, w_pop, w_len_err;
  logic             w_fifo_full, w_fifo_empty;
  cpl_entry_t       w_push_entry, w_head;

  assign w_size_zero = (s_axis_c2h_tuser_size == 16'd0);
  assign w_can_start = !w_fifo_full && (r_pend != CNT_W'(CPL_FIFO_DEPTH));
  assign w_in_hs     = s_axis_c2h_tvalid && w_s_tready;
  assign w_len       = (r_state == ST_IDLE) ? s_axis_c2h_tuser_size : r_len;
  assign w_qid       = (r_state == ST_IDLE) ? s_axis_c2h_tuser_qid : r_qid;
  assign w_exp       = (r_state == ST_IDLE) ? beats_of(s_axis_c2h_tuser_size) : r_exp_beats;
  assign w_beats_now = (r_state == ST_IDLE) ? 16'd1 : r_beat_cnt + 16'd1;
  assign w_mty       = s_axis_c2h_tlast ? mty_of(w_len) : 6'd0;
  assign w_beat      = {s_axis_c2h_tdata, s_axis_c2h_tlast, w_len, w_qid, w_mty};
  assign w_len_err   = w_fwd && s_axis_c2h_tlast && (w_beats_now != {5'd0, w_exp});

  always_ff @(posedge axis_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) r_state <= ST_IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_in_hs && !s_axis_c2h_tlast) w_next = w_size_zero ? ST_DROP : ST_PASS;
      ST_PASS: if (w_in_hs && s_axis_c2h_tlast) w_next = ST_IDLE;
      ST_DROP: if (w_in_hs && s_axis_c2h_tlast) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Starts wait for a completion slot; the skid gates only forwarding states.
  always_comb begin
    w_s_tready = 1'b0;
    w_start    = 1'b0;
    w_fwd      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_tready = r_rdy_en && !r_skid_valid && w_can_start;
        w_start    = s_axis_c2h_tvalid && w_s_tready;
        w_fwd      = w_start && !w_size_zero;
      end
      ST_PASS: begin
        w_s_tready = !r_skid_valid;
        w_fwd      = s_axis_c2h_tvalid && w_s_tready;
      end
      ST_DROP: w_s_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_rdy_en    <= 1'b0;
      r_len       <= '0;
      r_qid       <= '0;
      r_exp_beats <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_start) begin
        r_len       <= s_axis_c2h_tuser_size;
        r_qid       <= s_axis_c2h_tuser_qid;
        r_exp_beats <= beats_of(s_axis_c2h_tuser_size);
        r_beat_cnt  <= 16'd1;
      end else if (w_fwd) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  assign w_out_free = !r_out_valid || m_axis_qdma_c2h_tready;

  // Output register backed by a one-entry skid so ready can be registered.
  always_ff @(posedge axis_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_fwd;
        if (w_fwd) r_out <= w_beat;
      end
    end else if (w_fwd) begin
      r_skid       <= w_beat;
      r_skid_valid <= 1'b1;
    end
  end

  assign w_push       = r_out_valid && m_axis_qdma_c2h_tready && r_out[LAST_BIT];
  assign w_pop        = !w_fifo_empty && m_axis_qdma_cpl_tready;
  assign w_push_entry = {r_seq, 5'd0, r_out[LEN_LSB-1:QID_LSB], r_out[LAST_BIT-1:LEN_LSB]};

  always_ff @(posedge axis_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_pend           <= '0;
      r_seq            <= '0;
      stat_pkt_cnt     <= '0;
      stat_drop_cnt    <= '0;
      stat_len_err_cnt <= '0;
    end else begin
      case ({w_fwd && w_start, w_pop})
        2'b10:   r_pend <= r_pend + 1'b1;
        2'b01:   r_pend <= r_pend - 1'b1;
        default: ;
      endcase
      if (w_push) begin
        r_seq        <= r_seq + 32'd1;
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      end
      if (w_start && w_size_zero) stat_drop_cnt <= stat_drop_cnt + 32'd1;
      if (w_len_err) stat_len_err_cnt <= stat_len_err_cnt + 32'd1;
    end
  end

  c2h_cpl_fifo #(.DEPTH(CPL_FIFO_DEPTH)) u_cpl_fifo (
    .clk     (axis_aclk),
    .rst_n   (axil_aresetn),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign s_axis_c2h_tready             = w_s_tready;
  assign m_axis_qdma_c2h_tvalid        = r_out_valid;
  assign m_axis_qdma_c2h_tdata         = r_out[BW-1:LAST_BIT+1];
  assign m_axis_qdma_c2h_tlast         = r_out[LAST_BIT];
  assign m_axis_qdma_c2h_ctrl_len      = r_out[LAST_BIT-1:LEN_LSB];
  assign m_axis_qdma_c2h_ctrl_qid      = r_out[LEN_LSB-1:QID_LSB];
  assign m_axis_qdma_c2h_mty           = r_out[QID_LSB-1:0];
  assign m_axis_qdma_c2h_ctrl_has_cmpt = r_out_valid;
  assign m_axis_qdma_cpl_tvalid        = !w_fifo_empty;
  assign m_axis_qdma_cpl_tdata         = w_fifo_empty ? '0 : {{(DATA_W-64){1'b0}}, w_head};
  assign m_axis_qdma_cpl_size          = CPL_SIZE_8B;
  assign m_axis_qdma_cpl_ctrl_qid      = w_fifo_empty ? '0 : w_head.qid;
  assign o_dbg_state                   = r_state;

endmodule
